// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Requests are packed {addr, iswrite, data}, 65 bits wide.
package mem_arbiter_pkg;

  localparam int unsigned TIMEOUT_DEF  = 64;
  localparam logic [31:0] ERR_DATA_DEF = 32'hdeadbeef;

  typedef struct packed {
    logic [31:0] addr;
    logic        iswrite;
    logic [31:0] data;
  } req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. The pointer remembers who was granted last.
// It resets to m1 so that m0 wins the first contended pick.
module arb_rr2 (
  input  logic clk,
  input  logic resetn,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  always_comb begin
    gnt0 = req0 && (!req1 || last);
    gnt1 = req1 && (!req0 || !last);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one downstream port, one transaction at a time.
// It times out stalled transactions with an error response and sets a sticky err flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_rq_valid,
  input  logic [64:0] m0_rq,
  output logic        m0_rq_ready,
  output logic        m0_rs_valid,
  input  logic        m1_rq_valid,
  input  logic [64:0] m1_rq,
  output logic        m1_rq_ready,
  output logic        m1_rs_valid,
  output logic [31:0] m_rs_data,
  output logic        rq_en,
  output logic [64:0] rq,
  input  logic        rs_en,
  input  logic [31:0] rs_data,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          can_grant, g0, g1, grant;
  logic          timeout_hit, resp_real, resp_id;
  req_t          pick;

  assign can_grant = resetn && (state == ST_IDLE);

  arb_rr2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req0   (can_grant && m0_rq_valid),
    .req1   (can_grant && m1_rq_valid),
    .gnt0   (g0),
    .gnt1   (g1)
  );

  // A response arriving with a grant belongs to the new grant.
  assign grant       = g0 || g1;
  assign resp_real   = rs_en && (grant || (state == ST_WAIT));
  assign resp_id     = grant ? g1 : owner;
  assign timeout_hit = (state == ST_WAIT) && !rs_en && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    rq_en       = grant;
    m0_rq_ready = g0;
    m1_rq_ready = g1;
    pick        = g1 ? req_t'(m1_rq) : req_t'(m0_rq);
    rq          = pick;
    if (grant && !rs_en) begin
      state_nxt = ST_WAIT;
    end else if ((state == ST_WAIT) && (rs_en || timeout_hit)) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      cnt         <= '0;
      err         <= 1'b0;
      m0_rs_valid <= 1'b0;
      m1_rs_valid <= 1'b0;
      m_rs_data   <= 32'h0;
    end else begin
      state       <= state_nxt;
      m0_rs_valid <= (resp_real || timeout_hit) && !resp_id;
      m1_rs_valid <= (resp_real || timeout_hit) && resp_id;
      if (grant) begin
        owner <= g1;
        cnt   <= '0;
      end else if ((state == ST_WAIT) && (cnt != CW'(TIMEOUT))) begin
        cnt <= cnt + CW'(1);
      end
      if (resp_real) begin
        m_rs_data <= rs_data;
      end else if (timeout_hit) begin
        m_rs_data <= ERR_DATA;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (busy flag, owner, age since grant).
module tb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_rq_valid = 1'b0, m1_rq_valid = 1'b0;
  logic [64:0] m0_rq = '0, m1_rq = '0;
  logic        m0_rq_ready, m1_rq_ready, m0_rs_valid, m1_rs_valid;
  logic [31:0] m_rs_data;
  logic        rq_en;
  logic [64:0] rq;
  logic        rs_en = 1'b0;
  logic [31:0] rs_data = '0;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          mb_busy = 0, mb_owner = 0, mb_last = 1;
  int          mb_age = 0;
  bit          ev0 = 0, ev1 = 0, eerr = 0;
  logic [31:0] edata = 32'h0;

  mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hdeadbeef)) dut (
    .clk(clk), .resetn(resetn),
    .m0_rq_valid(m0_rq_valid), .m0_rq(m0_rq), .m0_rq_ready(m0_rq_ready), .m0_rs_valid(m0_rs_valid),
    .m1_rq_valid(m1_rq_valid), .m1_rq(m1_rq), .m1_rq_ready(m1_rq_ready), .m1_rs_valid(m1_rs_valid),
    .m_rs_data(m_rs_data), .rq_en(rq_en), .rq(rq), .rs_en(rs_en), .rs_data(rs_data), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit pick_winner();
    if (m0_rq_valid && !m1_rq_valid) return 1'b0;
    if (!m0_rq_valid && m1_rq_valid) return 1'b1;
    return !mb_last;
  endfunction

  task automatic advance();
    bit pulse, pid, w;
    logic [31:0] pdat;
    @(posedge clk);
    pulse = 0; pid = 0; pdat = '0;
    if (!resetn) begin
      mb_busy = 0; mb_last = 1; eerr = 0; edata = 32'h0;
    end else if (!mb_busy && (m0_rq_valid || m1_rq_valid)) begin
      w = pick_winner();
      mb_last = w;
      if (rs_en) begin
        pulse = 1; pid = w; pdat = rs_data;
      end else begin
        mb_busy = 1; mb_owner = w; mb_age = 1;
      end
    end else if (mb_busy) begin
      if (rs_en) begin
        pulse = 1; pid = mb_owner; pdat = rs_data; mb_busy = 0;
      end else if (mb_age == int'(TO)) begin
        pulse = 1; pid = mb_owner; pdat = 32'hdeadbeef; mb_busy = 0; eerr = 1;
      end else begin
        mb_age++;
      end
    end
    ev0 = pulse && !pid;
    ev1 = pulse && pid;
    if (pulse) edata = pdat;
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_rq_valid = 0; m1_rq_valid = 0; rs_en = 0; rs_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    advance();
    advance();
    resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0; m0_rq_valid = 1; m1_rq_valid = 1; rs_en = 1; rs_data = 32'h55;
    advance();
    settle();
    checks++; if (rq_en !== 1'b0) begin errors++; $display("FAIL reset_rq_en: got %b want 0", rq_en); end
    checks++; if (m0_rq_ready !== 1'b0 || m1_rq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", m0_rq_ready, m1_rq_ready); end
    checks++; if (m0_rs_valid !== 1'b0 || m1_rs_valid !== 1'b0) begin errors++; $display("FAIL reset_rs_valid: got %b%b want 00", m0_rs_valid, m1_rs_valid); end
    checks++; if (m_rs_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", m_rs_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    idle_inputs();
  endtask

  task automatic test_v1_read();
    do_reset();
    m0_rq_valid = 1; m0_rq = {32'h00000010, 1'b0, 32'h0};
    settle();
    checks++; if (rq_en !== 1'b1 || m0_rq_ready !== 1'b1 || m1_rq_ready !== 1'b0) begin errors++; $display("FAIL v1_grant: got en=%b r0=%b r1=%b want 1 1 0", rq_en, m0_rq_ready, m1_rq_ready); end
    checks++; if (rq !== {32'h00000010, 1'b0, 32'h0}) begin errors++; $display("FAIL v1_rq: got %h want %h", rq, {32'h00000010, 1'b0, 32'h0}); end
    advance();
    m0_rq_valid = 0; rs_en = 1; rs_data = 32'h12345678;
    settle();
    checks++; if (rq_en !== 1'b0 || m0_rs_valid !== 1'b0) begin errors++; $display("FAIL v1_wait: got en=%b v0=%b want 0 0", rq_en, m0_rs_valid); end
    advance();
    rs_en = 0;
    settle();
    checks++; if (m0_rs_valid !== 1'b1 || m1_rs_valid !== 1'b0 || m_rs_data !== 32'h12345678) begin errors++; $display("FAIL v1_resp: got v0=%b v1=%b d=%h want 1 0 12345678", m0_rs_valid, m1_rs_valid, m_rs_data); end
    advance();
    settle();
    checks++; if (m0_rs_valid !== 1'b0 || m_rs_data !== 32'h12345678) begin errors++; $display("FAIL v1_after: got v0=%b d=%h want 0 12345678", m0_rs_valid, m_rs_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_rq = {32'h100, 1'b0, 32'h0}; m1_rq = {32'h200, 1'b1, 32'h7};
    for (int i = 0; i < 4; i++) begin
      m0_rq_valid = 1; m1_rq_valid = 1; rs_en = 0;
      settle();
      checks++; if (m0_rq_ready !== 1'((i % 2) == 0) || m1_rq_ready !== 1'((i % 2) == 1)) begin errors++; $display("FAIL rr_order_%0d: got r0=%b r1=%b", i, m0_rq_ready, m1_rq_ready); end
      if (i > 0) begin
        checks++; if (m0_rs_valid !== 1'((i % 2) == 1) || m1_rs_valid !== 1'((i % 2) == 0) || m_rs_data !== 32'h100 + 32'(i - 1)) begin errors++; $display("FAIL rr_resp_%0d: got v0=%b v1=%b d=%h want d=%h", i, m0_rs_valid, m1_rs_valid, m_rs_data, 32'h100 + 32'(i - 1)); end
      end
      advance();
      rs_en = 1; rs_data = 32'h100 + 32'(i);
      settle();
      checks++; if (rq_en !== 1'b0 || m0_rq_ready !== 1'b0 || m1_rq_ready !== 1'b0) begin errors++; $display("FAIL rr_single_%0d: got en=%b during wait, want 0", i, rq_en); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_zero_latency();
    do_reset();
    m1_rq_valid = 1; m1_rq = {32'h10024048, 1'b1, 32'h000000aa};
    rs_en = 1; rs_data = 32'h0000600d;
    settle();
    checks++; if (m1_rq_ready !== 1'b1 || rq !== {32'h10024048, 1'b1, 32'h000000aa}) begin errors++; $display("FAIL v3_grant: got r1=%b rq=%h", m1_rq_ready, rq); end
    advance();
    m1_rq_valid = 0; rs_en = 0; m0_rq_valid = 1; m0_rq = {32'h44, 1'b0, 32'h0};
    settle();
    checks++; if (m1_rs_valid !== 1'b1 || m0_rs_valid !== 1'b0 || m_rs_data !== 32'h0000600d) begin errors++; $display("FAIL v3_resp: got v1=%b v0=%b d=%h want 1 0 0000600d", m1_rs_valid, m0_rs_valid, m_rs_data); end
    checks++; if (rq_en !== 1'b1 || m0_rq_ready !== 1'b1) begin errors++; $display("FAIL v3_regrant: got en=%b r0=%b want 1 1", rq_en, m0_rq_ready); end
    advance();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_rq_valid = 1; m0_rq = {32'h80, 1'b0, 32'h0};
    advance();
    m0_rq_valid = 0;
    for (int k = 1; k <= int'(TO); k++) begin
      settle();
      checks++; if (m0_rs_valid !== 1'b0 || rq_en !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got v0=%b en=%b err=%b want 0 0 0", k, m0_rs_valid, rq_en, err); end
      advance();
    end
    settle();
    checks++; if (m0_rs_valid !== 1'b1 || m_rs_data !== 32'hdeadbeef || err !== 1'b1) begin errors++; $display("FAIL to_pulse: got v0=%b d=%h err=%b want 1 deadbeef 1", m0_rs_valid, m_rs_data, err); end
    advance();
    settle();
    checks++; if (m0_rs_valid !== 1'b0) begin errors++; $display("FAIL to_one_pulse: got v0=%b want 0", m0_rs_valid); end
    advance();
    rs_en = 1; rs_data = 32'h11112222;
    advance();
    rs_en = 0;
    settle();
    checks++; if (m0_rs_valid !== 1'b0 || m1_rs_valid !== 1'b0 || err !== 1'b1 || m_rs_data !== 32'hdeadbeef) begin errors++; $display("FAIL to_late: got v0=%b v1=%b err=%b d=%h want 0 0 1 deadbeef", m0_rs_valid, m1_rs_valid, err, m_rs_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_rq_valid = 1; m1_rq = {32'h300, 1'b0, 32'h0};
    advance();
    resetn = 0; m0_rq_valid = 1; m1_rq_valid = 1;
    settle();
    checks++; if (rq_en !== 1'b0 || m0_rq_ready !== 1'b0 || m1_rq_ready !== 1'b0) begin errors++; $display("FAIL v5_in_reset: got en=%b r0=%b r1=%b want 0", rq_en, m0_rq_ready, m1_rq_ready); end
    advance();
    resetn = 1; m0_rq_valid = 0; m1_rq_valid = 0; rs_en = 1; rs_data = 32'h99;
    settle();
    checks++; if (m0_rs_valid !== 1'b0 || m1_rs_valid !== 1'b0 || m_rs_data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL v5_after_reset: got v0=%b v1=%b d=%h err=%b", m0_rs_valid, m1_rs_valid, m_rs_data, err); end
    advance();
    rs_en = 0; m0_rq_valid = 1; m1_rq_valid = 1;
    settle();
    checks++; if (m0_rs_valid !== 1'b0 || m1_rs_valid !== 1'b0) begin errors++; $display("FAIL v5_stray: got v0=%b v1=%b want 0 0", m0_rs_valid, m1_rs_valid); end
    checks++; if (m0_rq_ready !== 1'b1 || m1_rq_ready !== 1'b0) begin errors++; $display("FAIL v5_m0_first: got r0=%b r1=%b want 1 0", m0_rq_ready, m1_rq_ready); end
    advance();
    idle_inputs();
  endtask

  task automatic test_timeout_edge();
    do_reset();
    m0_rq_valid = 1; m0_rq = {32'h90, 1'b0, 32'h0};
    advance();
    m0_rq_valid = 0;
    for (int k = 1; k < int'(TO); k++) advance();
    rs_en = 1; rs_data = 32'h0000beef;
    advance();
    rs_en = 0;
    settle();
    checks++; if (m0_rs_valid !== 1'b1 || m_rs_data !== 32'h0000beef || err !== 1'b0) begin errors++; $display("FAIL v6_edge: got v0=%b d=%h err=%b want 1 0000beef 0", m0_rs_valid, m_rs_data, err); end
    advance();
  endtask

  task automatic test_random();
    bit e_en, w;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      resetn      = ($urandom_range(0, 99) != 0);
      m0_rq_valid = ($urandom_range(0, 2) != 0);
      m1_rq_valid = ($urandom_range(0, 2) != 0);
      m0_rq       = {$urandom(), 1'($urandom_range(0, 1)), $urandom()};
      m1_rq       = {$urandom(), 1'($urandom_range(0, 1)), $urandom()};
      rs_en       = ($urandom_range(0, 5) == 0);
      rs_data     = $urandom();
      settle();
      e_en = resetn && !mb_busy && (m0_rq_valid || m1_rq_valid);
      w = pick_winner();
      checks++; if (rq_en !== e_en || m0_rq_ready !== (e_en && !w) || m1_rq_ready !== (e_en && w)) begin errors++; $display("FAIL rnd_grant@%0d: got en=%b r0=%b r1=%b want %b %b %b", n, rq_en, m0_rq_ready, m1_rq_ready, e_en, e_en && !w, e_en && w); end
      if (e_en) begin
        checks++; if (rq !== (w ? m1_rq : m0_rq)) begin errors++; $display("FAIL rnd_rq@%0d: got %h want %h", n, rq, w ? m1_rq : m0_rq); end
      end
      checks++; if (m0_rs_valid !== ev0 || m1_rs_valid !== ev1 || m_rs_data !== edata || err !== eerr) begin errors++; $display("FAIL rnd_resp@%0d: got v0=%b v1=%b d=%h err=%b want %b %b %h %b", n, m0_rs_valid, m1_rs_valid, m_rs_data, err, ev0, ev1, edata, eerr); end
      advance();
    end
    idle_inputs();
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_v1_read();
    test_round_robin();
    test_zero_latency();
    test_timeout();
    test_reset_mid();
    test_timeout_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL be the number of cycles to wait for a downstream response before the block answers with an error.
REQ-002 Parameter ERR_DATA, default 32'hdeadbeef, SHALL be the response data returned on timeout.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-004 resetn  in  1  reset, synchronous and active-low.
REQ-005 m0_rq_valid/m1_rq_valid  in  1 each  requester has a request pending; m0 = processor, m1 = loader/debug.
REQ-006 m0_rq/m1_rq  in  65 each  request, packed as {addr[31:0], iswrite, data[31:0]}, so addr = [64:33], iswrite = [32], data = [31:0].
REQ-007 m0_rq_ready/m1_rq_ready  out  1 each  request accepted this cycle.
REQ-008 m0_rs_valid/m1_rs_valid  out  1 each  one-cycle response pulse.
REQ-009 m_rs_data  out  32  response data, shared by both requesters and qualified by mX_rs_valid.
REQ-010 rq_en  out  1  downstream request strobe.
REQ-011 rq  out  65  downstream request, same packing as REQ-006.
REQ-012 rs_en  in  1  downstream response strobe; sent for reads and writes alike.
REQ-013 rs_data  in  32  downstream response data.
REQ-014 err  out  1  sticky timeout flag.

Function
REQ-015 The block SHALL run a 2-state FSM: IDLE, WAIT.
REQ-016 At most one transaction SHALL be outstanding at any time; every accepted request SHALL get exactly one response.
REQ-017 Grant in IDLE:
- one requester valid: that requester SHALL be granted;
- both valid: the requester not granted last SHALL win;
- the last-granted pointer SHALL reset to 1, so m0 wins first.
REQ-018 Grant-cycle outputs:
- winner's mX_rq_ready = 1 combinationally;
- rq_en = 1 and rq = winner's request, passed through in the same cycle;
- the owner id SHALL be latched.
REQ-019 rq_en and both mX_rq_ready SHALL be 0 in WAIT and whenever no request is granted.
REQ-020 Downstream latency SHALL be accepted from 0 (rs_en in the grant cycle) up to TIMEOUT cycles.
REQ-021 On the first rs_en of a transaction:
- the next cycle SHALL drive m_rs_data = rs_data and owner's mX_rs_valid = 1 for exactly one cycle;
- FSM SHALL move to IDLE, or stay IDLE on a 0-latency response.
REQ-022 A new grant SHALL be allowed in the same cycle that mX_rs_valid is high.
REQ-023 Timeout counter:
- SHALL clear to 0 on grant and increment each WAIT cycle;
- width SHALL be clog2(TIMEOUT+1) bits with no wrap.
REQ-024 If the counter reaches TIMEOUT with no rs_en, the next cycle SHALL pulse the owner's mX_rs_valid with m_rs_data = ERR_DATA, set err = 1 and return to IDLE.
REQ-025 If rs_en arrives in the same cycle the counter reaches TIMEOUT, the real response SHALL win and err SHALL stay unchanged.
REQ-026 rs_en with no outstanding transaction, including a late response after a timeout, SHALL be ignored when no grant occurs that cycle.
REQ-027 rs_en arriving in the same cycle as a new grant SHALL be attributed to the new grant.
REQ-028 err SHALL clear only on reset.
REQ-029 m_rs_data SHALL hold its last value while both mX_rs_valid are 0.

Reset
REQ-030 While resetn = 0 the block SHALL reset to: FSM IDLE, pointer = 1, counter 0, err 0, m0_rs_valid/m1_rs_valid 0, m_rs_data 32'h0.
REQ-031 rq_en and mX_rq_ready SHALL be 0 during any cycle with resetn = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse; a downstream response in the cycle after reset SHALL be ignored per REQ-026.

Structure
REQ-033 Package mem_arbiter_pkg SHALL hold:
- the 65-bit request typedef with addr/iswrite/data field positions;
- the FSM state enum;
- default TIMEOUT and ERR_DATA.
REQ-034 The 2-way round-robin pick with pointer SHALL be one sub-module, arb_rr2; all other logic SHALL stay inline, in 120-400 RTL lines total.

Verification
REQ-035 Scenario V1: m0 only reads addr 32'h00000010, downstream answers 1 cycle later with 32'h12345678 -> rq_en for 1 cycle; m0_rs_valid pulses 2 cycles after grant with 32'h12345678; m1_rs_valid stays 0.
REQ-036 Scenario V2: m0 and m1 valid continuously, downstream latency 1 -> grant order m0, m1, m0, m1; never two outstanding transactions.
REQ-037 Scenario V3: m1 writes 32'h000000aa to 32'h10024048, rs_en in the grant cycle -> m1_rs_valid on the next cycle; a new grant is possible in that same cycle.
REQ-038 Scenario V4: m0 read with no rs_en, TIMEOUT = 8 -> m0_rs_valid with 32'hdeadbeef 9 cycles after grant; err = 1; a late rs_en 3 cycles later produces no pulse.
REQ-039 Scenario V5: resetn low in the WAIT cycle -> no response pulse; all outputs at their REQ-030/REQ-031 reset values; the next request is granted to m0 even if m1 is also valid.
REQ-040 Scenario V6: rs_en in the same cycle the counter reaches TIMEOUT with 32'h0000beef -> response 32'h0000beef; err stays 0.
